par_serializer: RTL and testbench

Parallel-to-serial front end for the n-bit serial shift register chain. It accepts N-bit words over a valid/ready handshake and drives them out one bit per clock on a single serial line, which connects directly to the shift register's serial data input. A one-word holding buffer lets consecutive words stream with no idle cycle between them. Frame and word-done strobes mark the first and last bit of each word.

---
 rtl/par_serializer_pkg.sv | 19 +
 rtl/par_serializer_bit_counter.sv | 31 +++
 rtl/par_serializer.sv | 114 +++++++++++
 tb/tb_par_serializer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/par_serializer_pkg.sv
// Shared defaults and state encoding for the parallel-to-serial front end.
// Benches and the downstream shift register chain take the word width from here.
package par_serializer_pkg;

    localparam int unsigned SER_N_DEFAULT         = 4;
    localparam bit          SER_MSB_FIRST_DEFAULT = 1'b1;
    localparam bit          SER_IDLE_LVL_DEFAULT  = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    // Bit position counter width; at least one bit even for tiny words.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/par_serializer_bit_counter.sv
// Modulo-N up-counter with load-zero and terminal-count decode.
// Shared with the matching deserializer, so it keeps the wrap even though the serializer never uses it.
module bit_counter
    import par_serializer_pkg::*;
#(
    parameter int unsigned N = SER_N_DEFAULT,
    localparam int unsigned W = cnt_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc_c
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc_c ? '0 : count + W'(1);
        end
    end

    assign tc_c = (count == LAST);

endmodule

// File: rtl/par_serializer.sv
// Parallel-to-serial front end: valid/ready word intake, one-word hold buffer,
// one bit per clock on Dout with frame_start/word_done marking the word boundaries.
module par_serializer
    import par_serializer_pkg::*;
#(
    parameter int unsigned N         = SER_N_DEFAULT,
    parameter bit          MSB_FIRST = SER_MSB_FIRST_DEFAULT,
    parameter bit          IDLE_LVL  = SER_IDLE_LVL_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] Din,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         Dout,
    output logic         frame_start,
    output logic         word_done,
    output logic         busy
);

    localparam int unsigned  CW   = cnt_width(N);
    localparam logic [N-1:0] FILL = {N{IDLE_LVL}};

    ser_state_t     state, state_d;
    logic [N-1:0]   shreg, hold, shifted;
    logic           hold_full;
    logic [CW-1:0]  count;
    logic           last_c;
    logic           accept, sh_load, sh_from_hold, sh_shift;
    logic           hold_load, hold_clr, go_idle, cnt_clr;

    assign load_ready = !hold_full;
    assign accept     = load_valid && load_ready;
    assign cnt_clr    = sh_load || go_idle;

    bit_counter #(.N(N)) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (sh_shift),
        .count (count),
        .tc_c  (last_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Word routing: a held word always wins the last-bit edge, since ready is low while it exists.
    always_comb begin
        state_d      = state;
        sh_load      = 1'b0;
        sh_from_hold = 1'b0;
        sh_shift     = 1'b0;
        hold_load    = 1'b0;
        hold_clr     = 1'b0;
        go_idle      = 1'b0;
        if (state == ST_IDLE) begin
            if (accept) begin
                sh_load = 1'b1;
                state_d = ST_SHIFT;
            end
        end else if (last_c) begin
            if (hold_full) begin
                sh_load      = 1'b1;
                sh_from_hold = 1'b1;
                hold_clr     = 1'b1;
            end else if (accept) begin
                sh_load = 1'b1;
            end else begin
                go_idle = 1'b1;
                state_d = ST_IDLE;
            end
        end else begin
            sh_shift  = 1'b1;
            hold_load = accept;
        end
    end

    // Vacated positions fill with the idle level so Dout is a plain flop tap in every state.
    assign shifted = MSB_FIRST ? {shreg[N-2:0], IDLE_LVL} : {IDLE_LVL, shreg[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= FILL;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (sh_load) begin
                shreg <= sh_from_hold ? hold : Din;
            end else if (sh_shift) begin
                shreg <= shifted;
            end else if (go_idle) begin
                shreg <= FILL;
            end
            if (hold_load) begin
                hold      <= Din;
                hold_full <= 1'b1;
            end else if (hold_clr) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign Dout        = MSB_FIRST ? shreg[N-1] : shreg[0];
    assign busy        = (state == ST_SHIFT);
    assign frame_start = busy && (count == '0);
    assign word_done   = busy && last_c;

endmodule

// File: tb/tb_par_serializer.sv
// Directed bench for par_serializer: MSB-first and LSB-first instances share stimulus,
// a word-queue model predicts every output each cycle, and hand literals pin the model.
module tb_par_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       load_valid;
    logic [1:0] load_ready, dout, frame_start, word_done, busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: up to two pending words per instance, head word's bit position.
    int         mcnt [2];
    int         mpos [2];
    logic [3:0] mw   [2][2];

    logic [31:0] mstream, lstream;

    always #5 clk = ~clk;

    par_serializer #(.N(4), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .Din(din), .load_valid(load_valid),
        .load_ready(load_ready[0]), .Dout(dout[0]), .frame_start(frame_start[0]),
        .word_done(word_done[0]), .busy(busy[0])
    );

    par_serializer #(.N(4), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)) dut_l (
        .clk(clk), .rst(rst), .Din(din), .load_valid(load_valid),
        .load_ready(load_ready[1]), .Dout(dout[1]), .frame_start(frame_start[1]),
        .word_done(word_done[1]), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mcnt[i] = 0;
                mpos[i] = 0;
            end else begin
                bit acc;
                acc = load_valid && (mcnt[i] < 2);
                if (mcnt[i] > 0) begin
                    mpos[i]++;
                    if (mpos[i] == 4) begin
                        mw[i][0] = mw[i][1];
                        mcnt[i]--;
                        mpos[i] = 0;
                    end
                end
                if (acc) begin
                    mw[i][mcnt[i]] = din;
                    mcnt[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic ed;
                ed = 1'b0;
                if (mcnt[i] > 0) ed = (i == 0) ? mw[i][0][3 - mpos[i]] : mw[i][0][mpos[i]];
                chk($sformatf("model_dout[%0d]", i),  32'(dout[i]),        32'(ed));
                chk($sformatf("model_busy[%0d]", i),  32'(busy[i]),        32'(mcnt[i] > 0));
                chk($sformatf("model_ready[%0d]", i), 32'(load_ready[i]),  32'(mcnt[i] < 2));
                chk($sformatf("model_fs[%0d]", i),    32'(frame_start[i]), 32'(mcnt[i] > 0 && mpos[i] == 0));
                chk($sformatf("model_wd[%0d]", i),    32'(word_done[i]),   32'(mcnt[i] > 0 && mpos[i] == 3));
            end
        end
    end

    task automatic step_rec();
        @(negedge clk);
        mstream = {mstream[30:0], dout[0]};
        lstream = {lstream[30:0], dout[1]};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq;
        rst        = 1'b1;
        load_valid = 1'b0;
        din        = 4'h0;
        mstream    = '0;
        lstream    = '0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_dout",  32'(dout[0]),       32'd0);
        chk("rst_ready", 32'(load_ready[0]), 32'd1);
        chk("rst_busy",  32'(busy[0]),       32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_busy",  32'(busy[0]),       32'd0);
        chk("idle_ready", 32'(load_ready[0]), 32'd1);
        chk("idle_dout",  32'(dout[0]),       32'd0);

        // Single word 1011, MSB first.
        seq = 4'b1011;
        din = 4'b1011; load_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step_rec();
            load_valid = 1'b0;
            chk($sformatf("single_dout_%0d", c), 32'(dout[0]),        32'(seq[3 - c]));
            chk($sformatf("single_fs_%0d", c),   32'(frame_start[0]), 32'(c == 0));
            chk($sformatf("single_wd_%0d", c),   32'(word_done[0]),   32'(c == 3));
        end
        @(negedge clk);
        chk("single_busy_end", 32'(busy[0]), 32'd0);
        chk("single_dout_end", 32'(dout[0]), 32'd0);

        // Back-to-back 1100 then 0011 with no gap.
        din = 4'b1100; load_valid = 1'b1;
        step_rec();
        din = 4'b0011;
        step_rec();
        load_valid = 1'b0;
        chk("b2b_ready_k1", 32'(load_ready[0]), 32'd0);
        step_rec();
        chk("b2b_ready_k2", 32'(load_ready[0]), 32'd0);
        step_rec();
        chk("b2b_ready_k3", 32'(load_ready[0]), 32'd0);
        step_rec();
        chk("b2b_ready_k4", 32'(load_ready[0]), 32'd1);
        repeat (3) step_rec();
        chk("b2b_stream", 32'(mstream[7:0]), 32'h000000C3);
        @(negedge clk);
        chk("b2b_busy_end", 32'(busy[0]), 32'd0);

        // Backpressure: third word offered while hold is full, Din disturbed meanwhile.
        din = 4'b1010; load_valid = 1'b1;
        step_rec();
        din = 4'b0110;
        step_rec();
        chk("bp_ready_k1", 32'(load_ready[0]), 32'd0);
        din = 4'b1111;
        step_rec();
        chk("bp_ready_k2", 32'(load_ready[0]), 32'd0);
        din = 4'b0000;
        step_rec();
        chk("bp_ready_k3", 32'(load_ready[0]), 32'd0);
        din = 4'b1111;
        step_rec();
        chk("bp_ready_k4", 32'(load_ready[0]), 32'd1);
        step_rec();
        chk("bp_ready_k5", 32'(load_ready[0]), 32'd0);
        load_valid = 1'b0;
        repeat (6) step_rec();
        chk("bp_stream", 32'(mstream[11:0]), 32'h00000A6F);
        @(negedge clk);
        chk("bp_busy_end", 32'(busy[0]), 32'd0);

        // 0001 on both instances: LSB first gives 1,0,0,0.
        din = 4'b0001; load_valid = 1'b1;
        step_rec();
        load_valid = 1'b0;
        repeat (3) step_rec();
        chk("lsb_stream", 32'(lstream[3:0]), 32'h8);
        chk("msb_stream", 32'(mstream[3:0]), 32'h1);
        @(negedge clk);

        // Reset during bit 2 with a held word pending.
        din = 4'b1100; load_valid = 1'b1;
        step_rec();
        din = 4'b1010;
        step_rec();
        chk("rstmid_ready_pre", 32'(load_ready[0]), 32'd0);
        rst = 1'b1; load_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_dout",  32'(dout[0]),       32'd0);
        chk("rstmid_busy",  32'(busy[0]),       32'd0);
        chk("rstmid_ready", 32'(load_ready[0]), 32'd1);
        rst = 1'b0;
        mstream = '0;
        repeat (8) step_rec();
        chk("rstmid_quiet", 32'(mstream[7:0]), 32'd0);
        chk("rstmid_busy_after", 32'(busy[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
